// File: rtl/lcd_key_event_gen.sv
// Direction-key front end for the LCD block-display controller: per-key sync and
// debounce, single-key press / auto-repeat event source, one-entry valid/ack buffer.

module lcd_key_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CW           = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_held
);
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_held;
  logic          w_lvl;

  assign w_lvl  = ~r_sync[1];
  assign o_held = r_held;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b11;
      r_cnt  <= '0;
      r_held <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_key_n};
      if (w_lvl == r_held) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYC - 1)) begin
        r_held <= ~r_held;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end
endmodule

module lcd_key_event_gen #(
  parameter int DEBOUNCE_CYC     = 1000000,
  parameter int REPEAT_DELAY_CYC = 25000000,
  parameter int REPEAT_RATE_CYC  = 5000000,
  parameter int CW               = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_key_n,
  input  logic       i_evt_ack,
  output logic       o_evt_valid,
  output logic [1:0] o_evt_dir,
  output logic       o_evt_rpt,
  output logic       o_evt_drop,
  output logic [3:0] o_key_held
);
  // Timers fire on reaching 0, so they are loaded one short of the period.
  localparam logic [CW-1:0] LD_DELAY = CW'(REPEAT_DELAY_CYC - 1);
  localparam logic [CW-1:0] LD_RATE  = CW'(REPEAT_RATE_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_RPT} state_t;

  logic [3:0]    w_held;
  logic          w_onehot;
  logic [1:0]    w_dir;
  state_t        r_state, w_nstate;
  logic [CW-1:0] r_timer, w_ntimer;
  logic [3:0]    r_key, w_nkey;
  logic          w_gen, w_rpt;
  logic          r_valid, r_rpt, r_drop;
  logic [1:0]    r_dir;

  for (genvar k = 0; k < 4; k++) begin : g_key
    lcd_key_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CW(CW)) u_db (
      .clk    (clk),
      .rst    (rst),
      .i_key_n(i_key_n[k]),
      .o_held (w_held[k])
    );
  end

  assign w_onehot = (w_held != 4'b0) && ((w_held & (w_held - 4'd1)) == 4'b0);

  // Bit 3 is up, so direction code is 3 minus the bit index.
  always_comb begin
    w_dir = 2'd0;
    case (w_held)
      4'b1000: w_dir = 2'd0;
      4'b0100: w_dir = 2'd1;
      4'b0010: w_dir = 2'd2;
      4'b0001: w_dir = 2'd3;
      default: w_dir = 2'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_timer <= '0;
      r_key   <= '0;
    end else begin
      r_state <= w_nstate;
      r_timer <= w_ntimer;
      r_key   <= w_nkey;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_ntimer = r_timer;
    w_nkey   = r_key;
    w_gen    = 1'b0;
    w_rpt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_onehot) begin
          w_gen    = 1'b1;
          w_ntimer = LD_DELAY;
          w_nkey   = w_held;
          w_nstate = S_ARM;
        end
      end
      S_ARM, S_RPT: begin
        // A key-pattern change outranks a due repeat.
        if (w_held != r_key) begin
          if (w_onehot) begin
            w_gen    = 1'b1;
            w_ntimer = LD_DELAY;
            w_nkey   = w_held;
            w_nstate = S_ARM;
          end else begin
            w_ntimer = '0;
            w_nkey   = '0;
            w_nstate = S_IDLE;
          end
        end else if (r_timer == '0) begin
          w_gen    = 1'b1;
          w_rpt    = 1'b1;
          w_ntimer = LD_RATE;
          w_nstate = S_RPT;
        end else begin
          w_ntimer = r_timer - 1'b1;
        end
      end
      default: begin
        w_ntimer = '0;
        w_nkey   = '0;
        w_nstate = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= 1'b0;
      r_dir   <= 2'd0;
      r_rpt   <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      if (w_gen && (!r_valid || i_evt_ack)) begin
        r_valid <= 1'b1;
        r_dir   <= w_dir;
        r_rpt   <= w_rpt;
      end else if (w_gen) begin
        r_drop <= 1'b1;
      end else if (i_evt_ack) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_evt_valid = r_valid;
  assign o_evt_dir   = r_dir;
  assign o_evt_rpt   = r_rpt;
  assign o_evt_drop  = r_drop;
  assign o_key_held  = w_held;
endmodule
